// File: rtl/vlsu_split_iq_if.sv
// vlsu_split_iq_if: request, load-issue, store-issue, completion and status signals of vlsu_split_iq; master = core/memory side, slave = queue
interface vlsu_split_iq_if #(
  parameter int ReqWidth    = 64,
  parameter int IdWidth     = 5,
  parameter int MaxInflight = 2
);
  localparam int IfW = $clog2(MaxInflight + 1);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [ReqWidth-1:0] req_bits_i;
  logic [IdWidth-1:0]  req_id_i;
  logic                req_is_load_i;
  logic                core_st_pending_i;
  logic                ld_valid_o;
  logic                ld_ready_i;
  logic [ReqWidth-1:0] ld_bits_o;
  logic [IdWidth-1:0]  ld_id_o;
  logic                st_valid_o;
  logic                st_ready_i;
  logic [ReqWidth-1:0] st_bits_o;
  logic [IdWidth-1:0]  st_id_o;
  logic                ld_done_i;
  logic                st_done_i;
  logic [IfW-1:0]      ld_inflight_o;
  logic [IfW-1:0]      st_inflight_o;
  logic                idle_o;
  logic                err_o;
  modport master (
    output req_valid_i, req_bits_i, req_id_i, req_is_load_i, core_st_pending_i,
           ld_ready_i, st_ready_i, ld_done_i, st_done_i,
    input  req_ready_o, ld_valid_o, ld_bits_o, ld_id_o, st_valid_o, st_bits_o, st_id_o,
           ld_inflight_o, st_inflight_o, idle_o, err_o
  );
  modport slave (
    input  req_valid_i, req_bits_i, req_id_i, req_is_load_i, core_st_pending_i,
           ld_ready_i, st_ready_i, ld_done_i, st_done_i,
    output req_ready_o, ld_valid_o, ld_bits_o, ld_id_o, st_valid_o, st_bits_o, st_id_o,
           ld_inflight_o, st_inflight_o, idle_o, err_o
  );
endinterface

// File: rtl/vlsu_split_iq.sv
// vlsu_split_iq: split load/store issue queues with cross-direction ordering tags; ports clk_i, rst_i (sync, active-high), io (vlsu_split_iq_if.slave)
module vlsu_split_iq #(
  parameter int ReqWidth    = 64,
  parameter int IdWidth     = 5,
  parameter int LdDepth     = 4,
  parameter int StDepth     = 4,
  parameter int MaxInflight = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vlsu_split_iq_if.slave io
);
  localparam int CntW = $clog2(LdDepth + StDepth + 2 * MaxInflight) + 1;
  localparam int IfW  = $clog2(MaxInflight + 1);
  localparam int LpW  = $clog2(LdDepth);
  localparam int SpW  = $clog2(StDepth);
  localparam int LcW  = $clog2(LdDepth + 1);
  localparam int ScW  = $clog2(StDepth + 1);
  localparam logic [IfW-1:0] MaxIf = IfW'(MaxInflight);
  logic [ReqWidth-1:0] ld_bits_q [LdDepth];
  logic [IdWidth-1:0]  ld_id_q   [LdDepth];
  logic [CntW-1:0]     ld_tag_q  [LdDepth];
  logic [ReqWidth-1:0] st_bits_q [StDepth];
  logic [IdWidth-1:0]  st_id_q   [StDepth];
  logic [CntW-1:0]     st_tag_q  [StDepth];
  logic [LpW-1:0] ld_wr, ld_rd;
  logic [SpW-1:0] st_wr, st_rd;
  logic [LcW-1:0] ld_cnt;
  logic [ScW-1:0] st_cnt;
  logic [CntW-1:0] ld_enq, ld_done, st_enq, st_done;
  logic [IfW-1:0] ld_infl, st_infl;
  logic err_q;
  logic ld_full, st_full, ld_push, st_push, ld_pop, st_pop, ld_done_ok, st_done_ok;
  assign ld_full = ld_cnt == LcW'(LdDepth);
  assign st_full = st_cnt == ScW'(StDepth);
  assign io.req_ready_o = !rst_i && (io.req_is_load_i ? !ld_full : !st_full);
  assign ld_push = io.req_valid_i && io.req_ready_o && io.req_is_load_i;
  assign st_push = io.req_valid_i && io.req_ready_o && !io.req_is_load_i;
  // A load waits until every store enqueued ahead of it has completed, and vice versa.
  assign io.ld_valid_o = !rst_i && ld_cnt != '0 && ld_tag_q[ld_rd] == st_done &&
                         !io.core_st_pending_i && ld_infl < MaxIf;
  assign io.st_valid_o = !rst_i && st_cnt != '0 && st_tag_q[st_rd] == ld_done && st_infl < MaxIf;
  assign ld_pop = io.ld_valid_o && io.ld_ready_i;
  assign st_pop = io.st_valid_o && io.st_ready_i;
  // A completion with nothing outstanding is a protocol error and is otherwise dropped.
  assign ld_done_ok = io.ld_done_i && (ld_infl != '0 || ld_pop);
  assign st_done_ok = io.st_done_i && (st_infl != '0 || st_pop);
  assign io.ld_bits_o = ld_bits_q[ld_rd];
  assign io.ld_id_o = ld_id_q[ld_rd];
  assign io.st_bits_o = st_bits_q[st_rd];
  assign io.st_id_o = st_id_q[st_rd];
  assign io.ld_inflight_o = ld_infl;
  assign io.st_inflight_o = st_infl;
  assign io.idle_o = ld_cnt == '0 && st_cnt == '0 && ld_infl == '0 && st_infl == '0;
  assign io.err_o = err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_wr <= '0;
      ld_rd <= '0;
      ld_cnt <= '0;
      st_wr <= '0;
      st_rd <= '0;
      st_cnt <= '0;
      ld_enq <= '0;
      ld_done <= '0;
      st_enq <= '0;
      st_done <= '0;
      ld_infl <= '0;
      st_infl <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < LdDepth; i++) ld_tag_q[i] <= '0;
      for (int i = 0; i < StDepth; i++) st_tag_q[i] <= '0;
    end else begin
      if (ld_push) begin
        ld_bits_q[ld_wr] <= io.req_bits_i;
        ld_id_q[ld_wr] <= io.req_id_i;
        ld_tag_q[ld_wr] <= st_enq;
        ld_wr <= ld_wr == LpW'(LdDepth - 1) ? '0 : ld_wr + 1'b1;
        ld_enq <= ld_enq + 1'b1;
      end
      if (st_push) begin
        st_bits_q[st_wr] <= io.req_bits_i;
        st_id_q[st_wr] <= io.req_id_i;
        st_tag_q[st_wr] <= ld_enq;
        st_wr <= st_wr == SpW'(StDepth - 1) ? '0 : st_wr + 1'b1;
        st_enq <= st_enq + 1'b1;
      end
      if (ld_pop) ld_rd <= ld_rd == LpW'(LdDepth - 1) ? '0 : ld_rd + 1'b1;
      if (st_pop) st_rd <= st_rd == SpW'(StDepth - 1) ? '0 : st_rd + 1'b1;
      ld_cnt <= ld_cnt + LcW'(ld_push) - LcW'(ld_pop);
      st_cnt <= st_cnt + ScW'(st_push) - ScW'(st_pop);
      ld_infl <= ld_infl + IfW'(ld_pop) - IfW'(ld_done_ok);
      st_infl <= st_infl + IfW'(st_pop) - IfW'(st_done_ok);
      if (ld_done_ok) ld_done <= ld_done + 1'b1;
      if (st_done_ok) st_done <= st_done + 1'b1;
      if ((io.ld_done_i && !ld_done_ok) || (io.st_done_i && !st_done_ok)) err_q <= 1'b1;
    end
  end
endmodule
